// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: redirect/stall control, instruction memory request/ack and the presented instruction.
interface fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    input  redirect, redirect_pc, stall, imem_ack, imem_rdata,
    output imem_req, imem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, stall, imem_ack, imem_rdata,
    input  imem_req, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM; ack->inst_valid in 1 cycle, stall holds the presented instruction.
// FETCH_PERF_CNT_EN adds the fetch_count output counting consumed instructions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  fetch_count
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, VALID, DISCARD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] redir_tgt;
  logic [1:0]  unused_redir_lsb;

  assign redir_tgt        = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redir_lsb = bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (bus.redirect) pc_d = redir_tgt;
      end
      REQ: begin
        if (bus.redirect) begin
          // The address cannot change until the in-flight request completes.
          if (bus.imem_ack) begin
            pc_d = redir_tgt;
          end else begin
            pend_pc_d = redir_tgt;
            state_d   = DISCARD;
          end
        end else if (bus.imem_ack) begin
          inst_d    = bus.imem_rdata;
          inst_pc_d = pc_q;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (bus.redirect) begin
          pc_d    = redir_tgt;
          state_d = REQ;
        end else if (!bus.stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = REQ;
        end
      end
      DISCARD: begin
        if (bus.imem_ack) begin
          pc_d    = bus.redirect ? redir_tgt : pend_pc_q;
          state_d = REQ;
        end else if (bus.redirect) begin
          pend_pc_d = redir_tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_req   = (state_q == REQ) || (state_q == DISCARD);
  assign bus.imem_addr  = pc_q;
  assign bus.inst_valid = (state_q == VALID);
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic        consume;

  assign consume = (state_q == VALID) && !bus.stall && !bus.redirect;

  always_ff @(posedge clk) begin
    if (reset)        fetch_count_q <= 32'h0;
    else if (consume) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule
